serial_dft_sequencer: RTL and testbench
=======================================

Name: serial_dft_sequencer

Overview:
Frame-level controller for the serial_fft_coral single-bin DFT accumulator datapath.
- Buffers one frame of FRAME_LENGTH multichannel samples from an upstream valid/ready stream.
- Replays the frame once per frequency bin k = 0..N_BINS-1, driving the datapath valid and sample inputs in lock-step with a twiddle ROM address (k*n) mod FRAME_LENGTH.
- Captures each bin result and presents it downstream on a valid/ready output.

Parameters:
X_WIDTH, 16, sample width per channel
S_WIDTH, 32, accumulator/result width per channel
FRAME_LENGTH, 8, samples per frame (N), >= 2
N_BINS, FRAME_LENGTH, bins computed per frame, 1..FRAME_LENGTH
CHANELS, 2, parallel channels

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  sequencer accepts sample
s_data  in  CHANELS*X_WIDTH  signed multichannel sample
dp_valid  out  1  drives datapath valid_i
dp_x  out  CHANELS*X_WIDTH  drives datapath x
tw_addr  out  clog2(FRAME_LENGTH)  twiddle ROM index, aligned with dp_valid
dp_counter  in  clog2(FRAME_LENGTH)  datapath counter, for alignment check
dp_valid_o  in  1  datapath result valid
dp_re  in  CHANELS*S_WIDTH  datapath real result
dp_im  in  CHANELS*S_WIDTH  datapath imag result
m_valid  out  1  bin result valid
m_ready  in  1  downstream accepts result
m_bin  out  clog2(FRAME_LENGTH)  bin index k
m_re  out  CHANELS*S_WIDTH  real part
m_im  out  CHANELS*S_WIDTH  imag part
m_last  out  1  high with the last bin (k = N_BINS-1)
sync_err  out  1  sticky: datapath counter misaligned

Behaviour:
- Reset values: s_ready=0, dp_valid=0, dp_x=0, tw_addr=0, m_valid=0, m_bin=0, m_re/m_im=0, m_last=0, sync_err=0; FSM returns to FILL. Reset mid-frame discards the buffer and any pending result.
- FSM states: FILL, RUN, WAIT, OUT.
- FILL:
  - s_ready=1.
  - Each s_valid&s_ready writes buf[wr_idx] and increments wr_idx.
  - On the write with wr_idx=N-1: wr_idx<=0, k<=0, n<=0, go RUN.
- RUN:
  - Every cycle: dp_valid=1, dp_x=buf[n], tw_addr=acc.
  - n increments; acc <= (acc+k) mod N, computed by conditional subtract, no multiplier.
  - On n=N-1: go WAIT, acc<=0.
  - Exactly N consecutive dp_valid cycles per bin, no gaps.
- WAIT:
  - dp_valid=0.
  - On dp_valid_o: register dp_re/dp_im into m_re/m_im, m_bin=k, m_last=(k==N_BINS-1), m_valid=1, go OUT.
  - dp_valid_o arrives the cycle after the last RUN beat.
- OUT:
  - Hold outputs stable while m_valid&!m_ready.
  - On handshake, m_valid<=0, then:
    - if k=N_BINS-1, go FILL;
    - else k<=k+1, n<=0, go RUN on the next cycle.
- s_ready=0 in RUN/WAIT/OUT. Frames are processed strictly serially.
- Alignment check: during each RUN beat, if dp_counter != n, set sync_err (cleared only by reset). The FSM continues regardless.
- dp_valid_o outside WAIT is ignored.
- Latency, first sample to bin 0 valid with m_ready held high: FILL N beats, RUN N cycles, WAIT 1, then output. Per additional bin: N+2 cycles.
- k=0 yields tw_addr=0 for all n, i.e. the DC bin.
- Widths: acc and n are clog2(N) bits; the wrap compare uses one extra bit to avoid overflow when N is not a power of two.

Decomposition:
- Package dft_seq_pkg: state enum (FILL, RUN, WAIT, OUT); localparam IDX_W = $clog2(FRAME_LENGTH); sample and result packed-array typedefs.
- Sub-module twiddle_addr_gen: inputs clk, rstn, clear, step, k; output addr.
  - Modular accumulator addr <= (addr+k) mod N on step; 0 on clear.

Test Plan:
1. N=4, N_BINS=4, frame x0=[1,2,3,4] (ch1=[4,3,2,1]), bench datapath model with 1-cycle valid_o, m_ready=1 -> tw_addr per bin: k0 0,0,0,0; k1 0,1,2,3; k2 0,2,0,2; k3 0,3,2,1; ch0 real results with exact twiddles 10,-2,-2,-2; m_last only on bin 3.
2. N=5, k=3 -> tw_addr 0,3,1,4,2 (non-power-of-2 wrap); sync_err stays 0.
3. Hold m_ready=0 for 10 cycles during bin 1 -> m_valid, m_bin=1, m_re and m_im stable; dp_valid stays 0 until the handshake; bin 2 RUN starts the cycle after.
4. s_valid toggling 1,0,1,1,0,1 during FILL -> exactly 4 samples stored in order; s_ready drops the cycle after the 4th accept.
5. Bench datapath counter offset by 1 -> sync_err=1 on the first RUN beat and stays 1; results still emitted.
6. rstn low for 1 cycle mid-RUN of bin 2 -> all outputs return to reset values; the next frame starts in FILL and produces correct bin 0.

Source files
------------

// File: rtl/dft_seq_pkg.sv
// Shared types and default sizing for the serial DFT frame sequencer.
package dft_seq_pkg;

  localparam int unsigned DEF_X_WIDTH      = 16;
  localparam int unsigned DEF_S_WIDTH      = 32;
  localparam int unsigned DEF_FRAME_LENGTH = 8;
  localparam int unsigned DEF_CHANELS      = 2;

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_WAIT,
    S_OUT
  } state_t;

  typedef logic [DEF_CHANELS-1:0][DEF_X_WIDTH-1:0] sample_t;
  typedef logic [DEF_CHANELS-1:0][DEF_S_WIDTH-1:0] result_t;

endpackage

// File: rtl/serial_dft_sequencer_twiddle_addr_gen.sv
// Modular twiddle index accumulator: addr <= (addr + k) mod FRAME_LENGTH per step.
module twiddle_addr_gen
  import dft_seq_pkg::*;
#(
  parameter int unsigned FRAME_LENGTH = DEF_FRAME_LENGTH,
  localparam int unsigned IDX_W = $clog2(FRAME_LENGTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             step,
  input  logic [IDX_W-1:0] k,
  output logic [IDX_W-1:0] addr
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(FRAME_LENGTH);

  logic [IDX_W-1:0] r_addr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W:0]   w_wrap;

  // One spare bit keeps addr+k from overflowing before the wrap compare.
  assign w_sum  = {1'b0, r_addr} + {1'b0, k};
  assign w_wrap = (w_sum >= N_EXT) ? (w_sum - N_EXT) : w_sum;
  assign addr   = r_addr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr <= '0;
    end else if (clear) begin
      r_addr <= '0;
    end else if (step) begin
      r_addr <= w_wrap[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/serial_dft_sequencer.sv
// Frame controller for a single-bin DFT accumulator: buffers a frame, replays it
// once per bin with matching twiddle addresses, and forwards each bin result.
module serial_dft_sequencer
  import dft_seq_pkg::*;
#(
  parameter int unsigned X_WIDTH      = DEF_X_WIDTH,
  parameter int unsigned S_WIDTH      = DEF_S_WIDTH,
  parameter int unsigned FRAME_LENGTH = DEF_FRAME_LENGTH,
  parameter int unsigned N_BINS       = FRAME_LENGTH,
  parameter int unsigned CHANELS      = DEF_CHANELS,
  localparam int unsigned IDX_W = $clog2(FRAME_LENGTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [CHANELS*X_WIDTH-1:0] s_data,
  output logic                       dp_valid,
  output logic [CHANELS*X_WIDTH-1:0] dp_x,
  output logic [IDX_W-1:0]           tw_addr,
  input  logic [IDX_W-1:0]           dp_counter,
  input  logic                       dp_valid_o,
  input  logic [CHANELS*S_WIDTH-1:0] dp_re,
  input  logic [CHANELS*S_WIDTH-1:0] dp_im,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [IDX_W-1:0]           m_bin,
  output logic [CHANELS*S_WIDTH-1:0] m_re,
  output logic [CHANELS*S_WIDTH-1:0] m_im,
  output logic                       m_last,
  output logic                       sync_err
);

  localparam int unsigned XW = CHANELS * X_WIDTH;
  localparam logic [IDX_W-1:0] LAST_N = IDX_W'(FRAME_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_BINS - 1);

  state_t           r_state;
  logic [XW-1:0]    r_buf [FRAME_LENGTH];
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_n;
  logic [IDX_W-1:0] r_k;

  logic             w_accept;
  logic             w_step;
  logic             w_clear;
  logic [IDX_W-1:0] w_n_next;
  logic [IDX_W-1:0] w_addr;

  assign w_accept = (r_state == S_FILL) && s_valid && s_ready;
  assign w_step   = (r_state == S_RUN) && (r_n != LAST_N);
  assign w_clear  = (r_state == S_RUN) && (r_n == LAST_N);
  assign w_n_next = r_n + IDX_W'(1);
  assign tw_addr  = w_addr;

  twiddle_addr_gen #(
    .FRAME_LENGTH(FRAME_LENGTH)
  ) u_addr_gen (
    .clk  (clk),
    .rstn (rstn),
    .clear(w_clear),
    .step (w_step),
    .k    (r_k),
    .addr (w_addr)
  );

  // Frame storage needs no reset: wr_idx restarts and contents are overwritten.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_idx] <= s_data;
    end
  end

  // Beat registers present beat r_n; entering RUN preloads beat 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_FILL;
      r_wr_idx <= '0;
      r_n      <= '0;
      r_k      <= '0;
      s_ready  <= 1'b0;
      dp_valid <= 1'b0;
      dp_x     <= '0;
      m_valid  <= 1'b0;
      m_bin    <= '0;
      m_re     <= '0;
      m_im     <= '0;
      m_last   <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          s_ready <= 1'b1;
          if (w_accept) begin
            if (r_wr_idx == LAST_N) begin
              r_wr_idx <= '0;
              r_k      <= '0;
              r_n      <= '0;
              s_ready  <= 1'b0;
              dp_valid <= 1'b1;
              dp_x     <= r_buf[0];
              r_state  <= S_RUN;
            end else begin
              r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
          end
        end
        S_RUN: begin
          if (r_n == LAST_N) begin
            dp_valid <= 1'b0;
            r_state  <= S_WAIT;
          end else begin
            r_n  <= w_n_next;
            dp_x <= r_buf[w_n_next];
          end
        end
        S_WAIT: begin
          if (dp_valid_o) begin
            m_re    <= dp_re;
            m_im    <= dp_im;
            m_bin   <= r_k;
            m_last  <= (r_k == LAST_K);
            m_valid <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (r_k == LAST_K) begin
              s_ready <= 1'b1;
              r_state <= S_FILL;
            end else begin
              r_k      <= r_k + IDX_W'(1);
              r_n      <= '0;
              dp_valid <= 1'b1;
              dp_x     <= r_buf[0];
              r_state  <= S_RUN;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Sticky flag: datapath sample counter disagrees with the replay index.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_err <= 1'b0;
    end else if ((r_state == S_RUN) && (dp_counter != r_n)) begin
      sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_dft_sequencer.sv
// Scoreboard bench: N=4 sequencer with an exact-twiddle datapath model, plus an N=5 instance for wrap.
module tb_serial_dft_sequencer;

  typedef struct {
    int     bin;
    bit     last;
    longint re0;
    longint im0;
    longint re1;
    longint im1;
  } res_t;

  logic clk;
  logic rstn;

  // N=4 instance
  logic        s_valid4, s_ready4, dp_valid4, dpv4, m_valid4, m_ready4, m_last4, sync_err4;
  logic [31:0] s_data4, dp_x4;
  logic [1:0]  tw_addr4, dp_counter4, m_bin4;
  logic [63:0] dre4, dim4, m_re4, m_im4;

  // N=5 instance
  logic        s_valid5, s_ready5, dp_valid5, dpv5, m_valid5, m_ready5, m_last5, sync_err5;
  logic [31:0] s_data5, dp_x5;
  logic [2:0]  tw_addr5, dp_counter5, m_bin5;
  logic [63:0] dre5, dim5, m_re5, m_im5;

  int n_chk = 0;
  int n_pass = 0;
  int unsigned bcnt4, off4, bcnt5;
  logic signed [31:0] acc_re4 [2];
  logic signed [31:0] acc_im4 [2];

  res_t res_q [$];
  int   addr_q [$];
  int   res5_q [$];
  int   addr5_q [$];

  int     X0 [5] = '{1, 2, 3, 4, 5};
  int     X1 [5] = '{4, 3, 2, 1, 0};
  longint RE0 [4] = '{10, -2, -2, -2};
  longint IM0 [4] = '{0, 2, 0, -2};
  longint RE1 [4] = '{10, 2, 2, 2};
  longint IM1 [4] = '{0, -2, 0, 2};

  serial_dft_sequencer #(
    .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(4), .N_BINS(4), .CHANELS(2)
  ) dut4 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4),
    .dp_valid(dp_valid4), .dp_x(dp_x4), .tw_addr(tw_addr4), .dp_counter(dp_counter4),
    .dp_valid_o(dpv4), .dp_re(dre4), .dp_im(dim4), .m_valid(m_valid4), .m_ready(m_ready4),
    .m_bin(m_bin4), .m_re(m_re4), .m_im(m_im4), .m_last(m_last4), .sync_err(sync_err4)
  );

  serial_dft_sequencer #(
    .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(5), .N_BINS(5), .CHANELS(2)
  ) dut5 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .dp_valid(dp_valid5), .dp_x(dp_x5), .tw_addr(tw_addr5), .dp_counter(dp_counter5),
    .dp_valid_o(dpv5), .dp_re(dre5), .dp_im(dim5), .m_valid(m_valid5), .m_ready(m_ready5),
    .m_bin(m_bin5), .m_re(m_re5), .m_im(m_im5), .m_last(m_last5), .sync_err(sync_err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dp_counter4 = 2'((bcnt4 + off4) % 4);
  assign dp_counter5 = 3'(bcnt5);
  assign dre5 = '0;
  assign dim5 = '0;
  assign m_ready5 = 1'b1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  // N=4 datapath model: exact twiddles W^m in {1, -j, -1, +j}, valid_o one cycle after the last beat.
  always @(posedge clk) begin : dp4_model
    logic signed [31:0] nre [2];
    logic signed [31:0] nim [2];
    logic signed [31:0] xv;
    if (!rstn) begin
      bcnt4 <= 0;
      dpv4  <= 1'b0;
      dre4  <= '0;
      dim4  <= '0;
      for (int c = 0; c < 2; c++) begin
        acc_re4[c] <= '0;
        acc_im4[c] <= '0;
      end
    end else begin
      dpv4 <= 1'b0;
      if (dp_valid4) begin
        for (int c = 0; c < 2; c++) begin
          xv = {{16{dp_x4[c*16+15]}}, dp_x4[c*16 +: 16]};
          nre[c] = acc_re4[c];
          nim[c] = acc_im4[c];
          case (tw_addr4)
            2'd0:    nre[c] = nre[c] + xv;
            2'd1:    nim[c] = nim[c] - xv;
            2'd2:    nre[c] = nre[c] - xv;
            default: nim[c] = nim[c] + xv;
          endcase
        end
        if (bcnt4 == 3) begin
          dpv4  <= 1'b1;
          dre4  <= {nre[1], nre[0]};
          dim4  <= {nim[1], nim[0]};
          bcnt4 <= 0;
          for (int c = 0; c < 2; c++) begin
            acc_re4[c] <= '0;
            acc_im4[c] <= '0;
          end
        end else begin
          bcnt4 <= bcnt4 + 1;
          for (int c = 0; c < 2; c++) begin
            acc_re4[c] <= nre[c];
            acc_im4[c] <= nim[c];
          end
        end
      end
    end
  end

  // N=5 datapath model: only beat counting and valid_o timing matter here.
  always @(posedge clk) begin
    if (!rstn) begin
      bcnt5 <= 0;
      dpv5  <= 1'b0;
    end else begin
      dpv5 <= 1'b0;
      if (dp_valid5) begin
        if (bcnt5 == 4) begin
          bcnt5 <= 0;
          dpv5  <= 1'b1;
        end else begin
          bcnt5 <= bcnt5 + 1;
        end
      end
    end
  end

  // Monitors: pop expectations whenever the DUTs present a beat or a result.
  always @(negedge clk) begin
    if (rstn && dp_valid4) begin
      if (addr_q.size() == 0) chk("tw_addr4_unexpected", 1, 0);
      else chk("tw_addr4", tw_addr4, addr_q.pop_front());
    end
    if (rstn && m_valid4 && m_ready4) begin
      if (res_q.size() == 0) chk("result4_unexpected", 1, 0);
      else begin
        res_t e;
        e = res_q.pop_front();
        chk("m_bin4", m_bin4, e.bin);
        chk("m_last4", m_last4, e.last);
        chk("m_re4_ch0", s32(m_re4[31:0]), e.re0);
        chk("m_im4_ch0", s32(m_im4[31:0]), e.im0);
        chk("m_re4_ch1", s32(m_re4[63:32]), e.re1);
        chk("m_im4_ch1", s32(m_im4[63:32]), e.im1);
      end
    end
    if (rstn && dp_valid5) begin
      if (addr5_q.size() == 0) chk("tw_addr5_unexpected", 1, 0);
      else chk("tw_addr5", tw_addr5, addr5_q.pop_front());
    end
    if (rstn && m_valid5 && m_ready5) begin
      if (res5_q.size() == 0) chk("result5_unexpected", 1, 0);
      else begin
        int b;
        b = res5_q.pop_front();
        chk("m_bin5", m_bin5, b);
        chk("m_last5", m_last5, (b == 4) ? 1 : 0);
      end
    end
  end

  task automatic push_frame4();
    for (int k = 0; k < 4; k++) begin
      res_t e;
      e.bin = k; e.last = (k == 3);
      e.re0 = RE0[k]; e.im0 = IM0[k]; e.re1 = RE1[k]; e.im1 = IM1[k];
      res_q.push_back(e);
      for (int n = 0; n < 4; n++) addr_q.push_back((k * n) % 4);
    end
  endtask

  task automatic push_frame5();
    for (int k = 0; k < 5; k++) begin
      res5_q.push_back(k);
      for (int n = 0; n < 5; n++) addr5_q.push_back((k * n) % 5);
    end
  endtask

  // Drives one frame; gappy applies the valid pattern 1,0,1,1,0,1.
  task automatic feed(input bit which, input bit gappy);
    int idx;
    int stp;
    int nsamp;
    bit v;
    bit acc;
    logic [5:0] pat;
    pat = 6'b101101;
    idx = 0;
    stp = 0;
    nsamp = which ? 5 : 4;
    @(posedge clk); #1;
    while (idx < nsamp && stp < 200) begin
      v = gappy ? pat[stp % 6] : 1'b1;
      if (which) begin
        s_valid5 = v; s_data5 = {16'(X1[idx]), 16'(X0[idx])};
      end else begin
        s_valid4 = v; s_data4 = {16'(X1[idx]), 16'(X0[idx])};
      end
      @(negedge clk);
      acc = v && (which ? s_ready5 : s_ready4);
      @(posedge clk); #1;
      if (acc) idx++;
      stp++;
    end
    s_valid4 = 1'b0;
    s_valid5 = 1'b0;
    chk("feed_count", idx, nsamp);
    if (gappy) chk("feed_gappy_cycles", stp, 6);
    @(negedge clk);
    chk("s_ready_drop", which ? s_ready5 : s_ready4, 0);
  endtask

  task automatic drain(input string name, input bit which);
    int c;
    c = 0;
    while (c < 400 && ((which ? res5_q.size() + addr5_q.size()
                              : res_q.size() + addr_q.size()) != 0)) begin
      @(negedge clk);
      c++;
    end
    chk(name, which ? res5_q.size() + addr5_q.size() : res_q.size() + addr_q.size(), 0);
  endtask

  task automatic check_reset4(input string tag);
    chk({tag, "_s_ready"}, s_ready4, 0);
    chk({tag, "_dp_valid"}, dp_valid4, 0);
    chk({tag, "_dp_x"}, dp_x4, 0);
    chk({tag, "_tw_addr"}, tw_addr4, 0);
    chk({tag, "_m_valid"}, m_valid4, 0);
    chk({tag, "_m_bin"}, m_bin4, 0);
    chk({tag, "_m_re"}, (m_re4 != 0) ? 1 : 0, 0);
    chk({tag, "_m_im"}, (m_im4 != 0) ? 1 : 0, 0);
    chk({tag, "_m_last"}, m_last4, 0);
    chk({tag, "_sync_err"}, sync_err4, 0);
  endtask

  initial begin
    int c;
    rstn = 1'b0; off4 = 0; m_ready4 = 1'b1;
    s_valid4 = 1'b0; s_data4 = '0; s_valid5 = 1'b0; s_data5 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset4("rst0");
    @(posedge clk); #1 rstn = 1'b1;

    // Non-power-of-two wrap on the N=5 instance.
    push_frame5();
    feed(1'b1, 1'b0);
    drain("drain5", 1'b1);
    chk("sync_err5", sync_err5, 0);

    // Full frame with gappy input valid.
    push_frame4();
    feed(1'b0, 1'b1);
    drain("drain_frame1", 1'b0);
    chk("sync_err4_frame1", sync_err4, 0);

    // Backpressure on bin 1.
    push_frame4();
    feed(1'b0, 1'b0);
    c = 0;
    while (!(m_valid4 && m_bin4 == 2'd0) && c < 100) begin @(negedge clk); c++; end
    chk("wait_bin0", m_valid4 && m_bin4 == 2'd0, 1);
    @(posedge clk); #1 m_ready4 = 1'b0;
    c = 0;
    while (!(m_valid4 && m_bin4 == 2'd1) && c < 100) begin @(negedge clk); c++; end
    chk("wait_bin1", m_valid4 && m_bin4 == 2'd1, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_m_valid", m_valid4, 1);
      chk("hold_m_bin", m_bin4, 1);
      chk("hold_m_re_ch0", s32(m_re4[31:0]), -2);
      chk("hold_m_im_ch1", s32(m_im4[63:32]), -2);
      chk("hold_dp_valid", dp_valid4, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 m_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bin2_run_start", dp_valid4, 1);
    chk("bin2_first_addr", tw_addr4, 0);
    drain("drain_frame2", 1'b0);

    // Datapath counter offset by one.
    off4 = 1;
    push_frame4();
    feed(1'b0, 1'b0);
    c = 0;
    while (!dp_valid4 && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    chk("sync_err_set", sync_err4, 1);
    drain("drain_frame3", 1'b0);
    chk("sync_err_sticky", sync_err4, 1);
    off4 = 0;

    // Reset in the middle of bin 2, then a clean frame.
    push_frame4();
    feed(1'b0, 1'b0);
    c = 0;
    while (res_q.size() > 2 && c < 200) begin @(negedge clk); c++; end
    c = 0;
    while (!dp_valid4 && c < 100) begin @(negedge clk); c++; end
    chk("mid_run_reached", dp_valid4, 1);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    res_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_reset4("rst_mid");
    push_frame4();
    feed(1'b0, 1'b0);
    drain("drain_frame4", 1'b0);
    chk("sync_err4_after_reset", sync_err4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end

endmodule
